// File: rtl/inst_mem_pipe.sv
// Instruction memory: word-addressed RAM with a stallable fixed-latency fetch port,
// a byte-enable debug port and a whole-array clear engine.
module inst_mem_pipe #(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter string       INIT_FILE    = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [29:0] fetch_addr,
    input  logic        fetch_stall,
    output logic        fetch_valid,
    output logic [31:0] fetch_data,
    output logic        fetch_fault,
    input  logic [29:0] debug_addr,
    input  logic [31:0] debug_input,
    input  logic [3:0]  debug_be,
    output logic [31:0] debug_data,
    input  logic        clear_start,
    output logic        busy
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned TAG_W = 30 - ADDR_WIDTH;
    localparam logic [TAG_W-1:0] BASE_TAG = BASE_ADDR[31:ADDR_WIDTH+2];

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    logic [31:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    logic                  fetch_hit_c, fetch_ok_c, debug_hit_c;
    logic [ADDR_WIDTH-1:0] fetch_idx_c, debug_idx_c;

    logic [READ_LATENCY-1:0] v_q;
    logic [READ_LATENCY-1:0] f_q;
    logic [31:0]             d_q [READ_LATENCY];

    assign fetch_hit_c = (fetch_addr[29:ADDR_WIDTH] == BASE_TAG);
    assign fetch_idx_c = fetch_addr[ADDR_WIDTH-1:0];
    assign fetch_ok_c  = fetch_hit_c & ~busy;
    assign debug_hit_c = (debug_addr[29:ADDR_WIDTH] == BASE_TAG);
    assign debug_idx_c = debug_addr[ADDR_WIDTH-1:0];

    // Clear engine state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy    <= (state_d == S_CLEAR);
        end
    end

    // Clear engine next state: sweep every word once, ignore restarts mid-sweep
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (clear_start) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == {ADDR_WIDTH{1'b1}}) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Array writes: clear has priority and locks out the debug port
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt_q] <= '0;
        end else if (debug_hit_c) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (debug_be[b]) mem[debug_idx_c][8*b +: 8] <= debug_input[8*b +: 8];
            end
        end
    end

    // Debug read port, read-first against same-cycle writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            debug_data <= '0;
        end else begin
            debug_data <= debug_hit_c ? mem[debug_idx_c] : '0;
        end
    end

    // Fetch pipeline; bubbles leave data/fault untouched so the outputs hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            f_q <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) d_q[i] <= '0;
        end else if (!fetch_stall) begin
            v_q[0] <= fetch_req;
            if (fetch_req) begin
                d_q[0] <= fetch_ok_c ? mem[fetch_idx_c] : '0;
                f_q[0] <= ~fetch_ok_c;
            end
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                v_q[i] <= v_q[i-1];
                if (v_q[i-1]) begin
                    d_q[i] <= d_q[i-1];
                    f_q[i] <= f_q[i-1];
                end
            end
        end
    end

    assign fetch_valid = v_q[READ_LATENCY-1];
    assign fetch_data  = d_q[READ_LATENCY-1];
    assign fetch_fault = f_q[READ_LATENCY-1];

endmodule
